// File: rtl/vga_timing_gen.sv
// Raster timing generator for the 800x480 text display.
// A pair of free-running counters walks the raster. The current pixel
// coordinate (i, j) goes combinationally to asciiwriter. One pipeline
// stage then registers the panel sync, data-enable and RGB, so that all
// of them line up with the colour asciiwriter returned for that pixel.
module vga_timing_gen #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 48,
  parameter int H_BP     = 40,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 13,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 29,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_ce,
  output logic [9:0] i,
  output logic [9:0] j,
  input  logic [7:0] red_in,
  input  logic [7:0] green_in,
  input  logic [7:0] blue_in,
  output logic [7:0] vga_r,
  output logic [7:0] vga_g,
  output logic [7:0] vga_b,
  output logic       hsync,
  output logic       vsync,
  output logic       de,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT_END   = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT_END   = 10'(V_ACTIVE);
  localparam logic [9:0] H_SYNC_BEG  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SYNC_END  = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_SYNC_BEG  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SYNC_END  = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       h_last;
  logic       v_last;
  logic       active;
  logic       h_in_sync;
  logic       v_in_sync;

  // The wrap tests use >= rather than ==. A count that is already past
  // the end, for example after the totals were changed, then still
  // returns to 0 on the next step.
  assign h_last    = (h_cnt >= H_LAST);
  assign v_last    = (v_cnt >= V_LAST);
  assign active    = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
  assign h_in_sync = (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END);
  assign v_in_sync = (v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END);

  // Coordinates to asciiwriter. They are zero outside the visible area.
  assign i = active ? h_cnt : 10'd0;
  assign j = active ? v_cnt : 10'd0;

  // Raster counters. They advance once per pixel enable, and the line
  // counter steps each time a line wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= 10'd0;
      v_cnt <= 10'd0;
    end else if (pix_ce) begin
      if (h_last) begin
        h_cnt <= 10'd0;
        v_cnt <= v_last ? 10'd0 : v_cnt + 10'd1;
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
    end
  end

  // Panel output stage. It captures timing and colour for the current
  // counter value, which puts every panel signal one pixel behind (i, j).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de    <= 1'b0;
      hsync <= ~SYNC_POL;
      vsync <= ~SYNC_POL;
      vga_r <= 8'd0;
      vga_g <= 8'd0;
      vga_b <= 8'd0;
    end else if (pix_ce) begin
      de    <= active;
      hsync <= h_in_sync ^ ~SYNC_POL;
      vsync <= v_in_sync ^ ~SYNC_POL;
      vga_r <= active ? red_in   : 8'd0;
      vga_g <= active ? green_in : 8'd0;
      vga_b <= active ? blue_in  : 8'd0;
    end
  end

  // Frame pulse. It lasts exactly one clk, whatever pix_ce does next, and
  // fires on the enabled edge that takes the raster back to (0, 0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_start <= 1'b0;
    end else begin
      frame_start <= pix_ce & h_last & v_last;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen, built around a reduced raster.
// The model follows one linear pixel index through the frame and works
// out the expected panel outputs from the region rules.
module tb_vga_timing_gen;

  localparam int HA = 16, HF = 3, HS = 4, HB = 2;
  localparam int VA = 6,  VF = 2, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;   // 25
  localparam int VT = VA + VF + VS + VB;   // 11
  localparam int FRAME = HT * VT;          // 275

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pix_ce = 1'b0;
  logic [7:0] red_in = 8'd0, green_in = 8'd0, blue_in = 8'd0;
  logic [9:0] i, j;
  logic [7:0] vga_r, vga_g, vga_b;
  logic       hsync, vsync, de, frame_start;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce), .i(i), .j(j),
    .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .hsync(hsync), .vsync(vsync), .de(de), .frame_start(frame_start)
  );

  // Clock: 10 time units per period, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state: the linear pixel index and the expected panel outputs.
  int          pos;
  logic        e_de, e_hs, e_vs, e_fs;
  logic [23:0] e_rgb;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (time %0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic in_active(input int p);
    return ((p % HT) < HA) && ((p / HT) < VA);
  endfunction

  function automatic logic in_hsync(input int p);
    return ((p % HT) >= HA + HF) && ((p % HT) < HA + HF + HS);
  endfunction

  function automatic logic in_vsync(input int p);
    return ((p / HT) >= VA + VF) && ((p / HT) < VA + VF + VS);
  endfunction

  task automatic model_reset();
    pos   = 0;
    e_de  = 1'b0;
    e_hs  = 1'b1;
    e_vs  = 1'b1;
    e_fs  = 1'b0;
    e_rgb = 24'd0;
  endtask

  // Works out what the panel outputs must hold after the next clock
  // edge, given the inputs that are being driven now.
  task automatic model_advance();
    e_fs = pix_ce && (pos == FRAME - 1);
    if (pix_ce) begin
      e_de  = in_active(pos);
      e_hs  = ~in_hsync(pos);
      e_vs  = ~in_vsync(pos);
      e_rgb = in_active(pos) ? {red_in, green_in, blue_in} : 24'd0;
      pos   = (pos + 1) % FRAME;
    end
  endtask

  task automatic compare();
    check("de", 32'(de), 32'(e_de));
    check("hsync", 32'(hsync), 32'(e_hs));
    check("vsync", 32'(vsync), 32'(e_vs));
    check("rgb", 32'({vga_r, vga_g, vga_b}), 32'(e_rgb));
    check("frame_start", 32'(frame_start), 32'(e_fs));
    check("i", 32'(i), in_active(pos) ? 32'(pos % HT) : 32'd0);
    check("j", 32'(j), in_active(pos) ? 32'(pos / HT) : 32'd0);
  endtask

  // One pixel step. Inputs are driven at a falling edge, the model is
  // advanced, and outputs are checked at the following falling edge.
  task automatic step(input logic ce, input logic [23:0] rgb);
    pix_ce = ce;
    {red_in, green_in, blue_in} = rgb;
    model_advance();
    @(negedge clk);
    compare();
  endtask

  initial begin
    int first_hs, first_fs, de_cnt, hs_cnt, vs_cnt;
    int fs_a, fs_b, ce_cnt, fs_ce;

    // Reset held with the clock running.
    model_reset();
    repeat (3) @(negedge clk);
    compare();
    check("reset_hsync_level", 32'(hsync), 32'd1);
    check("reset_vsync_level", 32'(vsync), 32'd1);

    // Constant enable and constant colour FF/00/80 for just over one frame.
    rst_n = 1'b1;
    first_hs = -1; first_fs = -1; de_cnt = 0; hs_cnt = 0; vs_cnt = 0;
    for (int k = 1; k <= 300; k++) begin
      step(1'b1, 24'hFF0080);
      if (k <= FRAME) begin
        if (de) de_cnt++;
        if (!hsync) hs_cnt++;
        if (!vsync) vs_cnt++;
      end
      if (!hsync && first_hs < 0) first_hs = k;
      if (frame_start && first_fs < 0) first_fs = k;
    end
    check("first_hsync_edge", 32'(first_hs), 32'd20);
    check("first_frame_start_edge", 32'(first_fs), 32'd275);
    check("de_per_frame", 32'(de_cnt), 32'd96);
    check("hsync_low_per_frame", 32'(hs_cnt), 32'd44);
    check("vsync_low_per_frame", 32'(vs_cnt), 32'd50);

    // Enable alternating 1,0: every period doubles, and outputs hold
    // while the enable is low.
    fs_a = -1; fs_b = -1;
    for (int k = 1; k <= 1200; k++) begin
      step((k % 2) == 1, 24'($urandom));
      if (frame_start) begin
        if (fs_a < 0) fs_a = k;
        else if (fs_b < 0) fs_b = k;
      end
    end
    check("frame_period_half_rate", 32'(fs_b - fs_a), 32'd550);

    // Random enable and random colour.
    for (int k = 0; k < 1500; k++) begin
      step($urandom_range(0, 3) != 0, 24'($urandom));
    end

    // Reset in the middle of a frame, at line 3 pixel 8.
    for (int k = 0; k < FRAME && pos != 3 * HT + 8; k++) begin
      step(1'b1, 24'($urandom));
    end
    check("reached_mid_frame", 32'(pos), 32'(3 * HT + 8));
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare();
    @(negedge clk);
    compare();
    rst_n = 1'b1;
    check("i_after_release", 32'(i), 32'd0);
    step(1'b1, 24'h123456);
    check("i_count_1", 32'(i), 32'd1);
    step(1'b1, 24'h654321);
    check("i_count_2", 32'(i), 32'd2);
    ce_cnt = 2; fs_ce = -1;
    for (int k = 0; k < 2000 && fs_ce < 0; k++) begin
      logic ce;
      ce = ($urandom_range(0, 2) != 0);
      step(ce, 24'($urandom));
      if (ce) ce_cnt++;
      if (frame_start) fs_ce = ce_cnt;
    end
    check("enables_to_first_frame_start", 32'(fs_ce), 32'd275);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
